cpu_writeback_arbiter: RTL and testbench
========================================

Name: cpu_writeback_arbiter

Overview:
Drives the single register-file write port (address, data, write enable) from two result sources. The primary source is the single-cycle ALU/datapath result, which always has priority and is never stalled. The secondary source is a long-latency unit (load/multiply/divide) with a valid/ready handshake. Secondary results are buffered in a small FIFO and drained into write-port cycles the primary does not use. A combinational pending-write query lets hazard logic stall on registers that still have a queued write.

Parameters:
DEPTH, 4, secondary FIFO entries; power of two, >= 2
AW, 2, log2(DEPTH); pointer width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
pri_valid  input  1  primary result present this cycle
pri_rd  input  5  primary destination register
pri_data  input  32  primary result
sec_valid  input  1  secondary result offered
sec_rd  input  5  secondary destination register
sec_data  input  32  secondary result
sec_ready  output  1  secondary beat accepted when sec_valid && sec_ready
wb_we  output  1  register-file write enable
wb_rd  output  5  register-file write address
wb_data  output  32  register-file write data
q_rd  input  5  pending-write query register
q_busy  output  1  q_rd has a queued secondary write
sec_count  output  AW+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (async, rst_n low):
  - FIFO flushed; read pointer, write pointer and count = 0.
  - sec_ready = 1 once rst_n is high. Until then sec_ready, wb_we and q_busy = 0.
  - Mid-operation reset discards all queued entries immediately; no write is issued for them.
- Write-port mux (combinational, zero latency):
  - If pri_valid: wb_we = (pri_rd != 0), wb_rd = pri_rd, wb_data = pri_data. The FIFO does not pop.
  - Else if FIFO non-empty: wb_we = 1, wb_rd = head.rd, wb_data = head.data. The FIFO pops at the clock edge.
  - Else: wb_we = 0, wb_rd = 0, wb_data = 0. (Bypass case: see Optional Feature.)
- sec_ready = (count != DEPTH). When full, sec_ready is 0 even if a pop occurs the same cycle; there is no pass-through when full.
- Secondary accept (sec_valid && sec_ready):
  - sec_rd == 0: beat consumed and dropped; nothing enqueued; count unchanged.
  - Otherwise: {rd, data} written at the write pointer; pointer increments mod DEPTH.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Push only: count + 1. Pop only: count − 1.
- Ordering:
  - Secondary writes retire in acceptance order.
  - A queued write is never reordered past a later secondary write.
  - Primary writes may overtake queued secondary writes. Hazard logic prevents write-after-write conflicts via q_busy.
- Minimum latency, secondary beat with FIFO empty and pri_valid low: accepted at edge N, written in cycle N+1.
- Starvation: with pri_valid continuously high, the FIFO never drains. After it fills, sec_ready stays 0 until a free cycle occurs.
- q_busy (combinational):
  - 1 iff q_rd != 0 and any occupied FIFO entry has rd == q_rd.
  - Includes the head entry while it is being written this cycle.
  - Excludes the beat currently on sec_* that has not yet been accepted.
- Pointers wrap from DEPTH−1 to 0. Count distinguishes full from empty.

Optional Feature:
Macro: WB_SECONDARY_BYPASS_EN
- Defined: if the FIFO is empty, pri_valid = 0, sec_valid = 1 and sec_rd != 0, the beat drives wb_* directly in the same cycle.
  - wb_we = 1, wb_rd = sec_rd, wb_data = sec_data.
  - The beat is consumed (sec_ready = 1) and not enqueued; count stays 0.
  - Minimum secondary latency is 0 cycles.
- Not defined: every secondary beat passes through the FIFO; minimum latency is 1 cycle; wb_* never depends combinationally on sec_*.

Test Plan:
1. Reset mid-queue: push 3 beats, assert rst_n low for 1 cycle -> sec_count = 0, wb_we = 0, q_busy = 0; no queued write appears after release.
2. Priority: pri_valid held high (rd=5, data=0x11), push sec rd=6 data=0xAA -> wb_rd = 5 every cycle. Drop pri_valid -> next cycle wb_we = 1, wb_rd = 6, wb_data = 0xAA; then count = 0.
3. Fill/backpressure (DEPTH=4): pri_valid high, push 4 beats -> sec_count = 4, sec_ready = 0. Release pri_valid -> 4 consecutive writes in order; sec_ready = 1 after the first pop edge.
4. x0 handling: pri_rd=0 with pri_valid -> wb_we = 0. Sec beat with rd=0 -> accepted, count stays 0, no write.
5. Wrap-around: 10 push/pop cycles alternating with simultaneous push+pop at count=2 -> data order preserved across pointer wrap; count constant during simultaneous push+pop.
6. q_busy: queue rd=9, q_rd=9 -> q_busy = 1; q_rd=0 -> 0. After the rd=9 write retires -> 0. With WB_SECONDARY_BYPASS_EN, empty FIFO, sec rd=7 data=0x55 -> same-cycle wb_we = 1, wb_rd = 7, count stays 0.

Source files
------------

// File: rtl/cpu_writeback_arbiter.sv
// Register-file write-port arbiter: the primary result always wins, and secondary results queue in a small FIFO.
// Define WB_SECONDARY_BYPASS_EN to let a secondary beat write in the same cycle when the FIFO is empty and the port is idle.
module cpu_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pri_valid,
  input  logic [4:0]    pri_rd,
  input  logic [31:0]   pri_data,
  input  logic          sec_valid,
  input  logic [4:0]    sec_rd,
  input  logic [31:0]   sec_data,
  output logic          sec_ready,
  output logic          wb_we,
  output logic [4:0]    wb_rd,
  output logic [31:0]   wb_data,
  input  logic [4:0]    q_rd,
  output logic          q_busy,
  output logic [AW:0]   sec_count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [4:0]      rd_mem   [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [AW-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]     count_reg, count_next;
  logic            fifo_empty, fifo_full;
  logic            bypass_hit, push, pop;
  logic [DEPTH-1:0] entry_hit;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_COUNT);
  // No pass-through when full, even if the head retires this cycle.
  assign sec_ready  = rst_n && !fifo_full;

`ifdef WB_SECONDARY_BYPASS_EN
  assign bypass_hit = rst_n && fifo_empty && !pri_valid && sec_valid && (sec_rd != 5'd0);
`else
  assign bypass_hit = 1'b0;
`endif

  // Beats for x0 are accepted and discarded; bypassed beats never enter the FIFO.
  assign push = sec_valid && sec_ready && (sec_rd != 5'd0) && !bypass_hit;
  assign pop  = rst_n && !pri_valid && !fifo_empty;

  always_comb begin
    wb_we   = 1'b0;
    wb_rd   = 5'd0;
    wb_data = 32'd0;
    if (rst_n) begin
      if (pri_valid) begin
        wb_we   = (pri_rd != 5'd0);
        wb_rd   = pri_rd;
        wb_data = pri_data;
      end else if (!fifo_empty) begin
        wb_we   = 1'b1;
        wb_rd   = rd_mem[rd_ptr_reg];
        wb_data = data_mem[rd_ptr_reg];
      end
`ifdef WB_SECONDARY_BYPASS_EN
      else if (bypass_hit) begin
        wb_we   = 1'b1;
        wb_rd   = sec_rd;
        wb_data = sec_data;
      end
`endif
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= sec_rd;
      data_mem[wr_ptr_reg] <= sec_data;
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [AW-1:0] offset;
      assign offset        = AW'(gi) - rd_ptr_reg;
      assign entry_hit[gi] = ({1'b0, offset} < count_reg) && (rd_mem[gi] == q_rd);
    end
  endgenerate

  assign q_busy    = rst_n && (q_rd != 5'd0) && (|entry_hit);
  assign sec_count = count_reg;

endmodule

// File: tb/tb_cpu_writeback_arbiter.sv
// Directed self-checking bench for cpu_writeback_arbiter (DEPTH=4).
// Bypass expectations follow WB_SECONDARY_BYPASS_EN when the bench is built with it.
module tb_cpu_writeback_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pri_valid;
  logic [4:0]  pri_rd;
  logic [31:0] pri_data;
  logic        sec_valid;
  logic [4:0]  sec_rd;
  logic [31:0] sec_data;
  logic        sec_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  q_rd;
  logic        q_busy;
  logic [2:0]  sec_count;

  int n_tests;
  int n_fail;

  cpu_writeback_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pri_valid (pri_valid),
    .pri_rd    (pri_rd),
    .pri_data  (pri_data),
    .sec_valid (sec_valid),
    .sec_rd    (sec_rd),
    .sec_data  (sec_data),
    .sec_ready (sec_ready),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .q_rd      (q_rd),
    .q_busy    (q_busy),
    .sec_count (sec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sec(input logic v, input logic [4:0] rd, input logic [31:0] d);
    sec_valid = v;
    sec_rd    = rd;
    sec_data  = d;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    pri_valid = 1'b0;
    pri_rd    = 5'd0;
    pri_data  = 32'd0;
    q_rd      = 5'd0;
    set_sec(1'b0, 5'd0, 32'd0);

    // Reset state
    #2;
    check_eq("rst_sec_ready", 32'(sec_ready), 32'd0);
    check_eq("rst_wb_we", 32'(wb_we), 32'd0);
    check_eq("rst_count", 32'(sec_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_sec_ready", 32'(sec_ready), 32'd1);

    // 1. Reset mid-queue: primary holds the port so three beats stay queued
    pri_valid = 1'b1; pri_rd = 5'd1; pri_data = 32'h1;
    for (int i = 0; i < 3; i++) begin
      set_sec(1'b1, 5'(3 + i), 32'hA0 + 32'(i));
      tick();
    end
    set_sec(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("t1_count_3", 32'(sec_count), 32'd3);
    q_rd = 5'd3;
    #1;
    check_eq("t1_qbusy_pre", 32'(q_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t1_count_rst", 32'(sec_count), 32'd0);
    check_eq("t1_we_rst", 32'(wb_we), 32'd0);
    check_eq("t1_qbusy_rst", 32'(q_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    pri_valid = 1'b0;
    #1;
    check_eq("t1_no_write_after", 32'(wb_we), 32'd0);
    tick();
    check_eq("t1_no_write_after2", 32'(wb_we), 32'd0);
    q_rd = 5'd0;

    // 2. Priority
    pri_valid = 1'b1; pri_rd = 5'd5; pri_data = 32'h11;
    set_sec(1'b1, 5'd6, 32'hAA);
    #1;
    check_eq("t2_wb_rd_pri", 32'(wb_rd), 32'd5);
    check_eq("t2_wb_data_pri", wb_data, 32'h11);
    tick();
    set_sec(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("t2_wb_rd_pri2", 32'(wb_rd), 32'd5);
    check_eq("t2_count_1", 32'(sec_count), 32'd1);
    tick();
    check_eq("t2_wb_rd_pri3", 32'(wb_rd), 32'd5);
    pri_valid = 1'b0;
    #1;
    check_eq("t2_sec_we", 32'(wb_we), 32'd1);
    check_eq("t2_sec_rd", 32'(wb_rd), 32'd6);
    check_eq("t2_sec_data", wb_data, 32'hAA);
    tick();
    check_eq("t2_count_0", 32'(sec_count), 32'd0);
    check_eq("t2_idle_we", 32'(wb_we), 32'd0);

    // 3. Fill / backpressure
    pri_valid = 1'b1; pri_rd = 5'd5; pri_data = 32'h11;
    for (int i = 0; i < 4; i++) begin
      set_sec(1'b1, 5'(10 + i), 32'h100 + 32'(i));
      tick();
    end
    set_sec(1'b1, 5'd14, 32'hDEAD);
    #1;
    check_eq("t3_count_full", 32'(sec_count), 32'd4);
    check_eq("t3_ready_full", 32'(sec_ready), 32'd0);
    tick();
    check_eq("t3_count_still_full", 32'(sec_count), 32'd4);
    set_sec(1'b0, 5'd0, 32'd0);
    pri_valid = 1'b0;
    #1;
    check_eq("t3_ready_full_popping", 32'(sec_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_drain%0d_we", i), 32'(wb_we), 32'd1);
      check_eq($sformatf("t3_drain%0d_rd", i), 32'(wb_rd), 32'(10 + i));
      check_eq($sformatf("t3_drain%0d_data", i), wb_data, 32'h100 + 32'(i));
      tick();
      if (i == 0) check_eq("t3_ready_after_pop", 32'(sec_ready), 32'd1);
    end
    check_eq("t3_count_0", 32'(sec_count), 32'd0);

    // 4. x0 handling
    pri_valid = 1'b1; pri_rd = 5'd0; pri_data = 32'h77;
    #1;
    check_eq("t4_pri_x0_we", 32'(wb_we), 32'd0);
    pri_valid = 1'b0;
    set_sec(1'b1, 5'd0, 32'h99);
    #1;
    check_eq("t4_sec_x0_ready", 32'(sec_ready), 32'd1);
    check_eq("t4_sec_x0_we", 32'(wb_we), 32'd0);
    tick();
    set_sec(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("t4_sec_x0_count", 32'(sec_count), 32'd0);
    check_eq("t4_sec_x0_we_after", 32'(wb_we), 32'd0);

    // 5. Wrap-around: preload 2, then steady push+pop for 10 cycles, then drain
    pri_valid = 1'b1; pri_rd = 5'd1; pri_data = 32'h1;
    for (int k = 0; k < 2; k++) begin
      set_sec(1'b1, 5'(16 + k), 32'hD000 + 32'(k));
      tick();
    end
    pri_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_sec(1'b1, 5'(18 + k), 32'hD000 + 32'(k + 2));
      #1;
      check_eq($sformatf("t5_c%0d_rd", k), 32'(wb_rd), 32'(16 + k));
      check_eq($sformatf("t5_c%0d_data", k), wb_data, 32'hD000 + 32'(k));
      tick();
      check_eq($sformatf("t5_c%0d_count", k), 32'(sec_count), 32'd2);
    end
    set_sec(1'b0, 5'd0, 32'd0);
    for (int k = 10; k < 12; k++) begin
      #1;
      check_eq($sformatf("t5_drain%0d_rd", k), 32'(wb_rd), 32'(16 + k));
      check_eq($sformatf("t5_drain%0d_data", k), wb_data, 32'hD000 + 32'(k));
      tick();
    end
    check_eq("t5_count_0", 32'(sec_count), 32'd0);

    // 6. q_busy
    pri_valid = 1'b1; pri_rd = 5'd5; pri_data = 32'h11;
    set_sec(1'b1, 5'd9, 32'h9);
    tick();
    set_sec(1'b0, 5'd0, 32'd0);
    q_rd = 5'd9;
    #1;
    check_eq("t6_qbusy_9", 32'(q_busy), 32'd1);
    q_rd = 5'd0;
    #1;
    check_eq("t6_qbusy_x0", 32'(q_busy), 32'd0);
    q_rd = 5'd9;
    pri_valid = 1'b0;
    #1;
    check_eq("t6_qbusy_retiring", 32'(q_busy), 32'd1);
    check_eq("t6_retire_rd", 32'(wb_rd), 32'd9);
    tick();
    check_eq("t6_qbusy_retired", 32'(q_busy), 32'd0);

    // Offered but unaccepted beat is not pending
    set_sec(1'b1, 5'd7, 32'h55);
    q_rd = 5'd7;
    #1;
    check_eq("t6_qbusy_offered", 32'(q_busy), 32'd0);
`ifdef WB_SECONDARY_BYPASS_EN
    check_eq("t6_byp_we", 32'(wb_we), 32'd1);
    check_eq("t6_byp_rd", 32'(wb_rd), 32'd7);
    check_eq("t6_byp_data", wb_data, 32'h55);
    tick();
    set_sec(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("t6_byp_count", 32'(sec_count), 32'd0);
    check_eq("t6_byp_no_repeat", 32'(wb_we), 32'd0);
`else
    check_eq("t6_nobyp_we", 32'(wb_we), 32'd0);
    tick();
    set_sec(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("t6_nobyp_qbusy", 32'(q_busy), 32'd1);
    check_eq("t6_nobyp_we1", 32'(wb_we), 32'd1);
    check_eq("t6_nobyp_rd", 32'(wb_rd), 32'd7);
    check_eq("t6_nobyp_data", wb_data, 32'h55);
    tick();
    check_eq("t6_nobyp_count", 32'(sec_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
